// File: rtl/iter_shift_unit_pkg.sv
// Shared definitions for the iterative shift unit: widths, op and FSM encodings.
package iter_shift_unit_pkg;

    localparam int unsigned DataW  = 8;
    localparam int unsigned ShamtW = 3;
    localparam int unsigned AmtW   = 8;

    typedef enum logic [1:0] {
        OpSll = 2'b00,
        OpSrl = 2'b01,
        OpSra = 2'b10,
        OpRor = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    // Any set bit above the meaningful shift-amount field shifts everything out.
    function automatic logic is_overshift(input logic [AmtW-1:0] amt);
        return |amt[AmtW-1:ShamtW];
    endfunction

endpackage

// File: rtl/iter_shift_unit_if.sv
// Request/response handshake bundle between the pipeline and the iterative shift unit.
interface iter_shift_unit_if;
    import iter_shift_unit_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [1:0]          op;
    logic [DataW-1:0]    operand;
    logic [AmtW-1:0]     shamt_in;
    logic                out_valid;
    logic                out_ready;
    logic [DataW-1:0]    result;
    logic                carry_out;
    logic                zero_flag;
    logic                busy;

    modport master (
        output in_valid, op, operand, shamt_in, out_ready,
        input  in_ready, out_valid, result, carry_out, zero_flag, busy
    );

    modport slave (
        input  in_valid, op, operand, shamt_in, out_ready,
        output in_ready, out_valid, result, carry_out, zero_flag, busy
    );

endinterface

// File: rtl/iter_shift_unit_shift_step.sv
// Combinational single-bit shift/rotate step; ROR only when ISHIFT_ROR_EN is defined.
module iter_shift_unit_shift_step
    import iter_shift_unit_pkg::*;
(
    input  op_e              op_i,
    input  logic [DataW-1:0] value_i,
    output logic [DataW-1:0] value_o,
    output logic             bit_o
);

    always_comb begin
        value_o = value_i;
        bit_o   = 1'b0;
        unique case (op_i)
            OpSll: begin
                value_o = {value_i[DataW-2:0], 1'b0};
                bit_o   = value_i[DataW-1];
            end
            OpSrl: begin
                value_o = {1'b0, value_i[DataW-1:1]};
                bit_o   = value_i[0];
            end
            OpSra: begin
                value_o = {value_i[DataW-1], value_i[DataW-1:1]};
                bit_o   = value_i[0];
            end
            OpRor: begin
`ifdef ISHIFT_ROR_EN
                value_o = {value_i[0], value_i[DataW-1:1]};
                bit_o   = value_i[0];
`else
                // Never reaches SHIFT without rotate support; hold value.
                value_o = value_i;
                bit_o   = 1'b0;
`endif
            end
            default: begin
                value_o = value_i;
                bit_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Iterative SLL/SRL/SRA unit, one bit per clock, with carry and zero flags.
// Define ISHIFT_ROR_EN to make op=11 a rotate-right; otherwise op=11 passes the operand through.
module iter_shift_unit
    import iter_shift_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    iter_shift_unit_if.slave bus
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [DataW-1:0]    work_q, work_d;
    logic                carry_q, carry_d;
    logic [ShamtW-1:0]   count_q, count_d;

    op_e                 req_op;
    logic [ShamtW-1:0]   req_amt;
    logic                accept;
    logic                over_eff;
    logic                no_shift;
    logic                sign_fill;
    logic [DataW-1:0]    step_value;
    logic                step_bit;

    assign req_op  = op_e'(bus.op);
    assign req_amt = bus.shamt_in[ShamtW-1:0];
    assign accept  = bus.in_valid && (state_q == StIdle);

`ifdef ISHIFT_ROR_EN
    assign over_eff = is_overshift(bus.shamt_in) && (req_op != OpRor);
    assign no_shift = (req_amt == '0);
`else
    // Without rotate support op=11 behaves like a zero-amount shift.
    assign over_eff = is_overshift(bus.shamt_in) && (req_op != OpRor);
    assign no_shift = (req_amt == '0) || (req_op == OpRor);
`endif

    assign sign_fill = (req_op == OpSra) && bus.operand[DataW-1];

    iter_shift_unit_shift_step u_shift_step (
        .op_i    (op_q),
        .value_i (work_q),
        .value_o (step_value),
        .bit_o   (step_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (over_eff || no_shift) ? StDone : StShift;
                end
            end
            StShift: begin
                if (count_q == ShamtW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.busy      = (state_q != StIdle);
        bus.result    = work_q;
        bus.carry_out = carry_q;
        bus.zero_flag = (state_q == StDone) && (work_q == '0);
    end

    // Datapath: load on accept, step while shifting, hold otherwise.
    always_comb begin
        op_d    = op_q;
        work_d  = work_q;
        carry_d = carry_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = req_op;
                    count_d = req_amt;
                    if (over_eff) begin
                        work_d  = sign_fill ? '1 : '0;
                        carry_d = sign_fill;
                    end else begin
                        work_d  = bus.operand;
                        carry_d = 1'b0;
                    end
                end
            end
            StShift: begin
                work_d  = step_value;
                carry_d = step_bit;
                count_d = count_q - ShamtW'(1);
            end
            default: begin
                work_d = work_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= OpSll;
            work_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            op_q    <= op_d;
            work_q  <= work_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: directed cases then randomized requests vs a model.
module tb_iter_shift_unit;
    import iter_shift_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    iter_shift_unit_if bus ();

    iter_shift_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-word arithmetic from the shift rules, latency in cycles from request.
    function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] sh,
                                  output logic [7:0] r, output logic c, output int lat);
        int          n;
        logic        over;
        logic [15:0] t;
        n    = int'(sh[2:0]);
        over = (sh[7:3] != 5'd0);
        r    = a;
        c    = 1'b0;
        lat  = n + 1;
        case (op)
            2'b00: begin
                t = {8'h00, a} << n;
                r = t[7:0];
                if (n > 0) c = a[8-n];
            end
            2'b01: begin
                r = a >> n;
                if (n > 0) c = a[n-1];
            end
            2'b10: begin
                r = 8'($signed(a) >>> n);
                if (n > 0) c = a[n-1];
            end
            default: begin
`ifdef ISHIFT_ROR_EN
                t = {a, a} >> n;
                r = t[7:0];
                if (n > 0) c = r[7];
`else
                lat = 1;
`endif
            end
        endcase
        if (over && op != 2'b11) begin
            lat = 1;
            if (op == 2'b10) begin
                r = {8{a[7]}};
                c = a[7];
            end else begin
                r = 8'h00;
                c = 1'b0;
            end
        end
    endfunction

    task automatic junk_inputs();
        bus.op       = 2'($urandom());
        bus.operand  = 8'($urandom());
        bus.shamt_in = 8'($urandom());
    endtask

    // One transaction: request, wait for result, optional backpressure, release.
    task automatic run_req(input logic [1:0] op, input logic [7:0] a, input logic [7:0] sh,
                           input int stall, input string tag);
        logic [7:0] er;
        logic       ec;
        int         el;
        int         lat;
        model(op, a, sh, er, ec, el);
        bus.op        = op;
        bus.operand   = a;
        bus.shamt_in  = sh;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        // Requests presented while busy must be ignored.
        junk_inputs();
        check({tag, ".in_ready"}, bus.in_ready, 0);
        check({tag, ".busy"}, bus.busy, 1);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            tick();
            junk_inputs();
            lat++;
        end
        check({tag, ".latency"}, lat, el);
        check({tag, ".result"}, bus.result, er);
        check({tag, ".carry"}, bus.carry_out, ec);
        check({tag, ".zero"}, bus.zero_flag, (er == 8'h00));
        for (int i = 0; i < stall; i++) begin
            tick();
            junk_inputs();
            check({tag, ".hold_valid"}, bus.out_valid, 1);
            check({tag, ".hold_ready"}, bus.in_ready, 0);
            check({tag, ".hold_result"}, bus.result, er);
            check({tag, ".hold_carry"}, bus.carry_out, ec);
            check({tag, ".hold_zero"}, bus.zero_flag, (er == 8'h00));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ".release_valid"}, bus.out_valid, 0);
        check({tag, ".release_idle"}, bus.in_ready, 1);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 2'b00;
        bus.operand   = 8'h00;
        bus.shamt_in  = 8'h00;
        tick();
        tick();
        check("rst.in_ready", bus.in_ready, 1);
        check("rst.out_valid", bus.out_valid, 0);
        check("rst.result", bus.result, 0);
        check("rst.carry", bus.carry_out, 0);
        check("rst.zero", bus.zero_flag, 0);
        check("rst.busy", bus.busy, 0);
        rst_n = 1'b1;
        tick();

        run_req(2'b00, 8'h81, 8'h03, 0, "sll");
        run_req(2'b10, 8'h90, 8'h02, 0, "sra");
        run_req(2'b01, 8'h90, 8'h02, 0, "srl");
        run_req(2'b01, 8'h00, 8'h00, 0, "n0");
        run_req(2'b10, 8'h80, 8'h09, 0, "over_sra");
        run_req(2'b00, 8'h80, 8'h09, 0, "over_sll");
        run_req(2'b01, 8'h80, 8'h40, 0, "over_srl");
        run_req(2'b00, 8'h3C, 8'h02, 5, "bp");
        run_req(2'b01, 8'hF0, 8'h04, 0, "after_bp");

        // Reset in the middle of a long shift discards the partial result.
        bus.op       = 2'b00;
        bus.operand  = 8'hA5;
        bus.shamt_in = 8'h07;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst.out_valid", bus.out_valid, 0);
        check("midrst.busy", bus.busy, 0);
        check("midrst.result", bus.result, 0);
        check("midrst.carry", bus.carry_out, 0);
        check("midrst.in_ready", bus.in_ready, 1);
        rst_n = 1'b1;
        tick();

        run_req(2'b11, 8'h01, 8'h01, 0, "op11");
        run_req(2'b11, 8'hB4, 8'h0A, 0, "op11_hi");
        run_req(2'b11, 8'h96, 8'h05, 1, "op11_5");

        for (int k = 0; k < 60; k++) begin
            logic [1:0] rop;
            logic [7:0] ra;
            logic [7:0] rsh;
            rop = 2'($urandom());
            ra  = 8'($urandom());
            rsh = ($urandom_range(3, 0) == 0) ? 8'($urandom()) : 8'($urandom_range(7, 0));
            run_req(rop, ra, rsh, int'($urandom_range(2, 0)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
